waveform_generator: RTL and testbench

- Stimulus source for the frequency-measurement path: produces a 12-bit sample stream with a programmable period in clock cycles.
- Its output connects directly to the frequency finder's serial_in.
- The period is stepped up and down by two active-low pushbuttons, each debounced to one step per press.
- The waveform shape is selectable. Period and shape changes are applied only at a period boundary, so every emitted period is clean.

---
 rtl/waveform_pkg.sv | 18 +
 rtl/waveform_generator_button.sv | 52 +++++
 rtl/waveform_generator.sv | 123 ++++++++++++
 tb/tb_waveform_generator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_pkg.sv
// Shared types and default limits for the waveform generator.
package waveform_pkg;

    typedef enum logic [1:0] {
        SQUARE   = 2'd0,
        RAMP     = 2'd1,
        TRIANGLE = 2'd2,
        ZERO     = 2'd3
    } mode_e;

    localparam int SAMPLE_MAX      = 4095;
    localparam int DEF_PERIOD      = 16;
    localparam int DEF_PERIOD_MIN  = 4;
    localparam int DEF_PERIOD_MAX  = 4096;
    localparam int DEF_PERIOD_STEP = 1;
    localparam int DEF_DEBOUNCE    = 4;

endpackage

// File: rtl/waveform_generator_button.sv
// Debounced active-low pushbutton: one step pulse per accepted press.
module button_stepper
    import waveform_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic step
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          step_q, step_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        step_d  = 1'b0;
        if (btn_n) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == LAST) begin
                step_d  = 1'b1;
                armed_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
            step_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            step_q  <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/waveform_generator.sv
// Programmable-period sample source; period and shape change only at
// a period boundary so every emitted period is clean.
module waveform_generator
    import waveform_pkg::*;
#(
    parameter int SAMPLE_W        = 12,
    parameter int PERIOD_W        = 32,
    parameter int PERIOD_DEFAULT  = DEF_PERIOD,
    parameter int PERIOD_MIN      = DEF_PERIOD_MIN,
    parameter int PERIOD_MAX      = DEF_PERIOD_MAX,
    parameter int PERIOD_STEP     = DEF_PERIOD_STEP,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pushbuttoni,
    input  logic                pushbuttond,
    input  logic [1:0]          mode,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sync,
    output logic [PERIOD_W-1:0] period_active
);

    localparam logic [PERIOD_W-1:0] P_DEF  = PERIOD_W'(PERIOD_DEFAULT);
    localparam logic [PERIOD_W-1:0] P_MIN  = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] P_MAX  = PERIOD_W'(PERIOD_MAX);
    localparam logic [PERIOD_W-1:0] P_STEP = PERIOD_W'(PERIOD_STEP);
    localparam logic [PERIOD_W-1:0] FULL   =
        PERIOD_W'((longint'(1) << SAMPLE_W) - 1);

    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] pend_q, pend_d;
    mode_e               mode_q, mode_d;
    logic [SAMPLE_W-1:0] smp_q, smp_d;
    logic                sync_q, sync_d;
    logic                inc, dec, last;

    button_stepper #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk   (clk),
        .reset (reset),
        .btn_n (pushbuttoni),
        .step  (inc)
    );

    button_stepper #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk   (clk),
        .reset (reset),
        .btn_n (pushbuttond),
        .step  (dec)
    );

    function automatic logic [SAMPLE_W-1:0] sat(
        input logic [PERIOD_W-1:0] v
    );
        return (v > FULL) ? '1 : v[SAMPLE_W-1:0];
    endfunction

    function automatic logic [SAMPLE_W-1:0] wave(
        input logic [PERIOD_W-1:0] p,
        input logic [PERIOD_W-1:0] per,
        input mode_e               m
    );
        logic [PERIOD_W-1:0] half;
        half = per >> 1;
        case (m)
            SQUARE:   return (p < half) ? '1 : '0;
            RAMP:     return sat(p);
            TRIANGLE: return (p < half) ? sat(p) : sat(per - 1'b1 - p);
            default:  return '0;
        endcase
    endfunction

    assign last = (phase_q == per_q - 1'b1);

    always_comb begin
        phase_d = phase_q;
        per_d   = per_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        smp_d   = smp_q;
        sync_d  = 1'b0;
        if (enable) begin
            smp_d   = wave(phase_q, per_q, mode_q);
            sync_d  = (phase_q == '0);
            phase_d = last ? '0 : phase_q + 1'b1;
            if (last) begin
                per_d  = pend_q;
                mode_d = mode_e'(mode);
            end
        end
        // Simultaneous up/down presses cancel out.
        if (inc && !dec) begin
            pend_d = (pend_q >= P_MAX - P_STEP) ? P_MAX : pend_q + P_STEP;
        end else if (dec && !inc) begin
            pend_d = (pend_q <= P_MIN + P_STEP) ? P_MIN : pend_q - P_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            per_q   <= P_DEF;
            pend_q  <= P_DEF;
            mode_q  <= SQUARE;
            smp_q   <= '0;
            sync_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            per_q   <= per_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            smp_q   <= smp_d;
            sync_q  <= sync_d;
        end
    end

    assign sample_out    = smp_q;
    assign sync          = sync_q;
    assign period_active = per_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Randomised bench for waveform_generator against a period-level
// reference model that expands whole periods into an expected queue.
module tb_waveform_generator;
    import waveform_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        bi = 1'b1;
    logic        bd = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] sample_out;
    logic        sync;
    logic [31:0] period_active;

    waveform_generator dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pushbuttoni   (bi),
        .pushbuttond   (bd),
        .mode          (mode),
        .sample_out    (sample_out),
        .sync          (sync),
        .period_active (period_active)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue holds the rest of the current period,
    // each entry = sample | (first_of_period << 16).
    int q[$];
    int m_per, m_pend, e_smp, e_sync;
    int run_i, run_d;
    bit st_i, st_d;

    function automatic int shape(int p, int per, int m);
        int half = per / 2;
        int a = (p > SAMPLE_MAX) ? SAMPLE_MAX : p;
        int b = (per - 1 - p > SAMPLE_MAX) ? SAMPLE_MAX : per - 1 - p;
        case (m)
            0:       return (p < half) ? SAMPLE_MAX : 0;
            1:       return a;
            2:       return (p < half) ? a : b;
            default: return 0;
        endcase
    endfunction

    task automatic build(int per, int m);
        for (int p = 0; p < per; p++)
            q.push_back(shape(p, per, m) | ((p == 0) ? 32'h10000 : 0));
    endtask

    task automatic model_edge();
        int np, v;
        if (reset) begin
            q.delete();
            m_per = 16; m_pend = 16;
            build(16, 0);
            e_smp = 0; e_sync = 0;
            run_i = 0; run_d = 0; st_i = 0; st_d = 0;
            return;
        end
        np = m_pend;
        if (st_i && !st_d) np = (m_pend + 1 > 4096) ? 4096 : m_pend + 1;
        if (st_d && !st_i) np = (m_pend - 1 < 4) ? 4 : m_pend - 1;
        if (enable) begin
            v = q.pop_front();
            e_smp = v & 32'hFFFF;
            e_sync = v >> 16;
            if (q.size() == 0) begin
                m_per = m_pend;
                build(m_per, int'(mode));
            end
        end else begin
            e_sync = 0;
        end
        m_pend = np;
        run_i = bi ? 0 : run_i + 1;
        run_d = bd ? 0 : run_d + 1;
        st_i = (run_i == 4);
        st_d = (run_d == 4);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("sample", int'(sample_out), e_smp);
        chk("sync", int'(sync), e_sync);
        chk("period", int'(period_active), m_per);
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic press(bit up, bit dn, int low);
        bi = ~up;
        bd = ~dn;
        repeat (low) cycle();
        bi = 1'b1;
        bd = 1'b1;
        cycle();
    endtask

    task automatic wait_syncs(int n, int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            cycle();
            t++;
            if (sync) seen++;
        end
        if (seen < n) chk("sync_timeout", seen, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        int rem_i, rem_d;
        enable = 1'b1;
        do_reset();
        chk("rst_period", int'(period_active), 16);
        cycle();
        chk("first_sync", int'(sync), 1);
        idle(40);

        mode = 2'd1;
        idle(40);
        wait_syncs(1, 100);
        idle(5);
        mode = 2'd2;
        idle(40);

        press(1, 0, 3);
        wait_syncs(2, 100);
        chk("press3", int'(period_active), 16);
        press(1, 0, 4);
        wait_syncs(2, 100);
        chk("press4", int'(period_active), 17);
        press(1, 0, 100);
        wait_syncs(2, 100);
        chk("press100", int'(period_active), 18);

        repeat (15) press(0, 1, 5);
        idle(3);
        wait_syncs(2, 100);
        chk("pmin", int'(period_active), 4);

        mode = 2'd0;
        repeat (4095) press(1, 0, 4);
        idle(3);
        wait_syncs(2, 9000);
        chk("pmax", int'(period_active), 4096);
        press(1, 1, 5);
        idle(3);
        wait_syncs(2, 9000);
        chk("both", int'(period_active), 4096);

        do_reset();
        idle(5);
        enable = 1'b0;
        bi = 1'b0;
        idle(5);
        bi = 1'b1;
        idle(5);
        enable = 1'b1;
        wait_syncs(2, 100);
        chk("frz_press", int'(period_active), 17);

        mode = 2'd1;
        do_reset();
        idle(9);
        reset = 1'b1;
        cycle();
        chk("rst_smp", int'(sample_out), 0);
        chk("rst_per", int'(period_active), 16);
        reset = 1'b0;
        idle(20);

        rem_i = 0;
        rem_d = 0;
        for (int k = 0; k < 4000; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if (rem_i == 0) begin
                bi = 1'($urandom_range(0, 1));
                rem_i = $urandom_range(1, 7);
            end
            if (rem_d == 0) begin
                bd = 1'($urandom_range(0, 1));
                rem_d = $urandom_range(1, 7);
            end
            rem_i--;
            rem_d--;
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
